// File: rtl/imm_encoder.sv
// imm_encoder: two-stage pipelined RISC-V immediate encoder with range check and valid/ready handshakes
//
// Ports:
//   clk_i        sole clock, rising edge
//   rst_ni       asynchronous active-low reset
//   in_valid_i   request valid
//   in_ready_o   request accepted this cycle when high together with in_valid_i
//   imm_src_i    target instruction format
//   imm_i        immediate / byte offset to encode
//   opcode_i, rd_i, rs1_i, rs2_i, funct3_i  non-immediate instruction fields
//   out_valid_o  encoded instruction valid
//   out_ready_i  consumer accepts instruction
//   instr_o      encoded instruction word (NOP when err_o)
//   err_o        immediate not representable in the selected format
//   enc_count_o  saturating count of error-free instructions delivered

package cpu_pkg;
   localparam int WIDTH = 32;
   typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_src_t;
endpackage

module imm_encoder
   import cpu_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  imm_src_t         imm_src_i,
   input  logic [WIDTH-1:0] imm_i,
   input  logic [6:0]       opcode_i,
   input  logic [4:0]       rd_i,
   input  logic [4:0]       rs1_i,
   input  logic [4:0]       rs2_i,
   input  logic [2:0]       funct3_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [31:0]      instr_o,
   output logic             err_o,
   output logic [CNT_W-1:0] enc_count_o
);
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic             s1_valid, s1_err, in_err, s2_adv, accept;
   imm_src_t         s1_src;
   logic [WIDTH-1:0] s1_imm;
   logic [6:0]       s1_op;
   logic [4:0]       s1_rd, s1_rs1, s1_rs2;
   logic [2:0]       s1_f3;
   logic [31:0]      s2_instr_d;
   logic             sx11, sx12, sx20;

   // S2 can take a new word when it is empty or its word leaves this cycle
   assign s2_adv     = !out_valid_o || out_ready_i;
   assign in_ready_o = !s1_valid || s2_adv;
   assign accept     = in_valid_i && in_ready_o;

   // sign-extension checks: all bits above the format's sign bit must match it
   assign sx11 = &imm_i[WIDTH-1:11] || ~|imm_i[WIDTH-1:11];
   assign sx12 = &imm_i[WIDTH-1:12] || ~|imm_i[WIDTH-1:12];
   assign sx20 = &imm_i[WIDTH-1:20] || ~|imm_i[WIDTH-1:20];

   always_comb begin
      in_err = 1'b1;
      case (imm_src_i)
         IMM_I, IMM_S: in_err = !sx11;
         IMM_B:        in_err = !sx12 || imm_i[0];
         IMM_J:        in_err = !sx20 || imm_i[0];
         IMM_U:        in_err = |imm_i[11:0];
         default:      in_err = 1'b1;
      endcase
   end

   always_comb begin
      s2_instr_d = NOP;
      case (s1_src)
         IMM_I: s2_instr_d = {s1_imm[11:0], s1_rs1, s1_f3, s1_rd, s1_op};
         IMM_S: s2_instr_d = {s1_imm[11:5], s1_rs2, s1_rs1, s1_f3, s1_imm[4:0], s1_op};
         IMM_B: s2_instr_d = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_f3, s1_imm[4:1], s1_imm[11], s1_op};
         IMM_U: s2_instr_d = {s1_imm[31:12], s1_rd, s1_op};
         IMM_J: s2_instr_d = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_rd, s1_op};
         default: s2_instr_d = NOP;
      endcase
      if (s1_err) s2_instr_d = NOP;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_valid    <= 1'b0;
         s1_err      <= 1'b0;
         s1_src      <= IMM_I;
         s1_imm      <= '0;
         s1_op       <= '0;
         s1_rd       <= '0;
         s1_rs1      <= '0;
         s1_rs2      <= '0;
         s1_f3       <= '0;
         out_valid_o <= 1'b0;
         instr_o     <= '0;
         err_o       <= 1'b0;
         enc_count_o <= '0;
      end else begin
         if (in_ready_o) s1_valid <= in_valid_i;
         if (accept) begin
            s1_err <= in_err;
            s1_src <= imm_src_i;
            s1_imm <= imm_i;
            s1_op  <= opcode_i;
            s1_rd  <= rd_i;
            s1_rs1 <= rs1_i;
            s1_rs2 <= rs2_i;
            s1_f3  <= funct3_i;
         end
         if (s2_adv) out_valid_o <= s1_valid;
         if (s2_adv && s1_valid) begin
            instr_o <= s2_instr_d;
            err_o   <= s1_err;
         end
         if (out_valid_o && out_ready_i && !err_o && !(&enc_count_o))
            enc_count_o <= enc_count_o + 1'b1;
      end
   end
endmodule
